operand_stage: RTL and testbench

Issue/operand-fetch pipeline stage between decode and execute. Drives the register file read addresses from the decoded instruction, selects each operand from the register file data or the writeback bypass, and registers the result into a one-entry output buffer with valid/ready handshakes. A per-register scoreboard blocks issue of an instruction while any register it reads or writes still has a write in flight, so operands are never stale.

---
 rtl/operand_stage_if.sv | 43 ++++
 rtl/operand_stage.sv | 99 +++++++++
 tb/tb_operand_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/operand_stage_if.sv
// Bundle of the decode, register file, writeback, flush and execute-side signals of operand_stage.
// The slave modport is the stage's own view; master is the surrounding pipeline's view.
interface operand_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [RW-1:0]   in_rs1;
    logic [RW-1:0]   in_rs2;
    logic [RW-1:0]   in_rd;
    logic            in_we;
    logic [RW-1:0]   ra1;
    logic [RW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wb_we;
    logic [RW-1:0]   wb_wa;
    logic [XLEN-1:0] wb_wd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [RW-1:0]   out_rd;
    logic            out_we;

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_we,
        input  rd1, rd2, wb_we, wb_wa, wb_wd, flush, out_ready,
        output in_ready, ra1, ra2,
        output out_valid, out_pc, out_op1, out_op2, out_rd, out_we
    );

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_we,
        output rd1, rd2, wb_we, wb_wa, wb_wd, flush, out_ready,
        input  in_ready, ra1, ra2,
        input  out_valid, out_pc, out_op1, out_op2, out_rd, out_we
    );
endinterface

// File: rtl/operand_stage.sv
// Operand fetch / issue stage: scoreboarded hazard check, operand select and one-entry output buffer.
// Optional writeback-to-source bypass enabled by defining OPERAND_BYPASS_EN.
module operand_stage (
    input  logic            clk,
    input  logic            rst,
    operand_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    logic [NREG-1:1] pending;
    logic [NREG-1:0] pend_full;
    logic [NREG-1:0] pend_nxt;

    logic            byp1, byp2;
    logic            src1_busy, src2_busy, dst_busy;
    logic            wb_clr, hazard, accept, ready_c;
    logic [XLEN-1:0] op1_c, op2_c;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q, out_op1_q, out_op2_q;
    logic [4:0]      out_rd_q;
    logic            out_we_q;

    assign pend_full = {pending, 1'b0};
    assign bus.ra1   = bus.in_rs1;
    assign bus.ra2   = bus.in_rs2;

`ifdef OPERAND_BYPASS_EN
    assign byp1  = bus.wb_we && (bus.wb_wa == bus.in_rs1) && (bus.in_rs1 != 5'd0);
    assign byp2  = bus.wb_we && (bus.wb_wa == bus.in_rs2) && (bus.in_rs2 != 5'd0);
    assign op1_c = (bus.in_rs1 == 5'd0) ? '0 : (byp1 ? bus.wb_wd : bus.rd1);
    assign op2_c = (bus.in_rs2 == 5'd0) ? '0 : (byp2 ? bus.wb_wd : bus.rd2);
`else
    logic unused_wd;
    assign unused_wd = ^bus.wb_wd;
    assign byp1  = 1'b0;
    assign byp2  = 1'b0;
    assign op1_c = (bus.in_rs1 == 5'd0) ? '0 : bus.rd1;
    assign op2_c = (bus.in_rs2 == 5'd0) ? '0 : bus.rd2;
`endif

    // Hazard detection: RAW on sources, WAW on destination (a same-cycle writeback releases it)
    assign wb_clr    = bus.wb_we && (bus.wb_wa != 5'd0);
    assign src1_busy = pend_full[bus.in_rs1] && (bus.in_rs1 != 5'd0) && !byp1;
    assign src2_busy = pend_full[bus.in_rs2] && (bus.in_rs2 != 5'd0) && !byp2;
    assign dst_busy  = bus.in_we && (bus.in_rd != 5'd0) && pend_full[bus.in_rd]
                       && !(wb_clr && (bus.wb_wa == bus.in_rd));
    assign hazard    = bus.in_valid && (src1_busy || src2_busy || dst_busy);
    assign ready_c   = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept    = bus.in_valid && ready_c;
    assign bus.in_ready = ready_c;

    // Scoreboard next state: clears first, then the issuing set takes priority
    always_comb begin
        pend_nxt = pend_full;
        if (wb_clr)
            pend_nxt[bus.wb_wa] = 1'b0;
        if (bus.flush && out_valid_q && out_we_q && (out_rd_q != 5'd0))
            pend_nxt[out_rd_q] = 1'b0;
        if (accept && bus.in_we && (bus.in_rd != 5'd0))
            pend_nxt[bus.in_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
        end else begin
            pending <= pend_nxt[NREG-1:1];
            if (bus.flush)
                out_valid_q <= 1'b0;
            else if (accept)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
            if (accept) begin
                out_pc_q  <= bus.in_pc;
                out_op1_q <= op1_c;
                out_op2_q <= op2_c;
                out_rd_q  <= bus.in_rd;
                out_we_q  <= bus.in_we;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_op1   = out_op1_q;
    assign bus.out_op2   = out_op2_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_we    = out_we_q;
endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage; expectations follow OPERAND_BYPASS_EN when defined.
module tb_operand_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:1] exp_p;

    operand_stage_if bus();
    operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic [31:0] d1, input logic [31:0] d2);
        bus.in_valid = v;  bus.in_pc = pc;  bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_rd = rd;    bus.in_we = we;  bus.rd1 = d1;     bus.rd2 = d2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.wb_we = 1'b0; bus.wb_wa = 5'd0; bus.wb_wd = 32'h0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_checks++; if ({bus.out_pc, bus.out_op1, bus.out_op2} !== 96'h0) begin n_fail++; $display("FAIL rst_data: got %h %h %h want 0", bus.out_pc, bus.out_op1, bus.out_op2); end
        n_checks++; if ({bus.out_rd, bus.out_we} !== 6'h0) begin n_fail++; $display("FAIL rst_rd_we: got %h %b want 0", bus.out_rd, bus.out_we); end
        n_checks++; if (dut.pending !== 31'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", dut.pending); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22);
        #1;
        n_checks++; if ({bus.ra1, bus.ra2} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL basic_ra: got %0d %0d want 1 2", bus.ra1, bus.ra2); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", bus.in_ready); end
        step();
        drive(1'b0, 32'h0, 5'd4, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0);
        exp_p = '0; exp_p[3] = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
        n_checks++; if ({bus.out_pc, bus.out_op1, bus.out_op2} !== {32'h100, 32'h11, 32'h22}) begin n_fail++; $display("FAIL basic_data: got %h %h %h want 100 11 22", bus.out_pc, bus.out_op1, bus.out_op2); end
        n_checks++; if ({bus.out_rd, bus.out_we} !== {5'd3, 1'b1}) begin n_fail++; $display("FAIL basic_rd: got %0d %b want 3 1", bus.out_rd, bus.out_we); end
        n_checks++; if (dut.pending !== exp_p) begin n_fail++; $display("FAIL basic_pending: got %h want %h", dut.pending, exp_p); end
        // reset in the middle of an accept and a writeback wipes everything
        rst = 1'b1;
        drive(1'b1, 32'h104, 5'd0, 5'd0, 5'd8, 1'b1, 32'h0, 32'h0);
        bus.wb_we = 1'b1; bus.wb_wa = 5'd3;
        step();
        rst = 1'b0; bus.wb_we = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if ({bus.out_valid, dut.pending} !== 32'h0) begin n_fail++; $display("FAIL midrst: got %b %h want 0 0", bus.out_valid, dut.pending); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 32'h200, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
        step();
        drive(1'b1, 32'h204, 5'd5, 5'd0, 5'd6, 1'b1, 32'h1234, 32'h0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b want 0", bus.in_ready); end
        step();
        bus.wb_we = 1'b1; bus.wb_wa = 5'd5; bus.wb_wd = 32'hDEAD;
        #1;
`ifdef OPERAND_BYPASS_EN
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready: got %b want 1", bus.in_ready); end
        step();
        bus.wb_we = 1'b0; bus.wb_wd = 32'h0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
`else
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL nobyp_wb_stall: got %b want 0", bus.in_ready); end
        step();
        bus.wb_we = 1'b0; bus.wb_wd = 32'h0; bus.rd1 = 32'hDEAD;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL nobyp_ready: got %b want 1", bus.in_ready); end
        step();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
`endif
        exp_p = '0; exp_p[6] = 1'b1;
        n_checks++; if ({bus.out_valid, bus.out_pc, bus.out_op1} !== {1'b1, 32'h204, 32'hDEAD}) begin n_fail++; $display("FAIL dep_out: got %b %h %h want 1 204 dead", bus.out_valid, bus.out_pc, bus.out_op1); end
        n_checks++; if (dut.pending !== exp_p) begin n_fail++; $display("FAIL dep_pending: got %h want %h", dut.pending, exp_p); end
    endtask

    task automatic test_zero();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready%0d: got %b want 1", i, bus.in_ready); end
            step();
            n_checks++; if ({bus.out_op1, bus.out_op2} !== 64'h0) begin n_fail++; $display("FAIL zero_ops%0d: got %h %h want 0 0", i, bus.out_op1, bus.out_op2); end
        end
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (dut.pending !== 31'h0) begin n_fail++; $display("FAIL zero_pending: got %h want 0", dut.pending); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 1'b0, 32'hAA, 32'hBB);
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h404, 5'd3, 5'd0, 5'd0, 1'b0, 32'hCC, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, bus.in_ready); end
            n_checks++; if ({bus.out_valid, bus.out_pc, bus.out_op1, bus.out_op2} !== {1'b1, 32'h400, 32'hAA, 32'hBB}) begin n_fail++; $display("FAIL bp_hold%0d: got %b %h %h %h want 1 400 aa bb", i, bus.out_valid, bus.out_pc, bus.out_op1, bus.out_op2); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", bus.in_ready); end
        step();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if ({bus.out_valid, bus.out_pc, bus.out_op1} !== {1'b1, 32'h404, 32'hCC}) begin n_fail++; $display("FAIL bp_next: got %b %h %h want 1 404 cc", bus.out_valid, bus.out_pc, bus.out_op1); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h500, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
        step();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
        step();
        bus.flush = 1'b0;
        n_checks++; if ({bus.out_valid, dut.pending} !== 32'h0) begin n_fail++; $display("FAIL flush_clear: got %b %h want 0 0", bus.out_valid, dut.pending); end
        drive(1'b1, 32'h504, 5'd7, 5'd0, 5'd0, 1'b0, 32'h77, 32'h0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reader: got %b want 1", bus.in_ready); end
        step();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if ({bus.out_valid, bus.out_op1} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL flush_op: got %b %h want 1 77", bus.out_valid, bus.out_op1); end
    endtask

    task automatic test_waw();
        do_reset();
        drive(1'b1, 32'h600, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
        step();
        drive(1'b1, 32'h604, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall%0d: got %b want 0", i, bus.in_ready); end
            step();
        end
        bus.wb_we = 1'b1; bus.wb_wa = 5'd9; bus.wb_wd = 32'h9;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_ready: got %b want 1", bus.in_ready); end
        step();
        bus.wb_we = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        exp_p = '0; exp_p[9] = 1'b1;
        n_checks++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h604}) begin n_fail++; $display("FAIL waw_out: got %b %h want 1 604", bus.out_valid, bus.out_pc); end
        n_checks++; if (dut.pending !== exp_p) begin n_fail++; $display("FAIL waw_pending: got %h want %h", dut.pending, exp_p); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700 + 32'(i * 4), 5'd1, 5'd2, 5'(10 + i), 1'b1, 32'(i), 32'(i + 16));
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.in_ready); end
            step();
            n_checks++; if ({bus.out_pc, bus.out_op1, bus.out_rd} !== {32'h700 + 32'(i * 4), 32'(i), 5'(10 + i)}) begin n_fail++; $display("FAIL b2b_out%0d: got %h %h %0d", i, bus.out_pc, bus.out_op1, bus.out_rd); end
        end
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        exp_p = '0; exp_p[10] = 1'b1; exp_p[11] = 1'b1; exp_p[12] = 1'b1; exp_p[13] = 1'b1;
        n_checks++; if (dut.pending !== exp_p) begin n_fail++; $display("FAIL b2b_pending: got %h want %h", dut.pending, exp_p); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_backpressure();
        test_flush();
        test_waw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
